// File: rtl/adc_scan_scheduler.sv
// adc_scan_scheduler: steps the ADC controller through the enabled channels once per scan
// period. Each (channel, sample) result is queued in a small FIFO, and each queued entry is
// sent to uart_tx as a 3-byte frame: sync byte, channel, data.
module adc_scan_scheduler #(
   parameter int unsigned SCAN_DIV     = 50000,
   parameter int unsigned CONV_TIMEOUT = 4096,
   parameter int unsigned FIFO_DEPTH   = 4,
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic [7:0] ch_mask,
   output logic       conv_start,
   output logic [2:0] conv_ch,
   input  logic       conv_done,
   input  logic [7:0] conv_data,
   output logic       tx_send,
   output logic [7:0] tx_data,
   input  logic       tx_ready,
   output logic       scan_busy,
   output logic [7:0] ovf_cnt,
   output logic       timeout_err
);

   localparam int TICK_W = $clog2(SCAN_DIV);
   localparam int TMO_W  = $clog2(CONV_TIMEOUT + 1);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;

   typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_STORE, S_NEXT} scan_state_t;
   typedef enum logic [1:0] {T_IDLE, T_B0, T_B1, T_B2} tx_state_t;
   typedef enum logic [1:0] {P_SEND, P_LOW, P_HIGH} tx_phase_t;

   logic [TICK_W-1:0] tick_cnt;
   logic              tick;

   scan_state_t       scan_state, scan_next;
   logic [7:0]        round_mask;
   logic [7:0]        ch_onehot;
   logic [TMO_W-1:0]  tmo_cnt;
   logic              tmo_expire;
   logic [7:0]        sample;

   logic [10:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  fifo_cnt;
   logic              fifo_push, fifo_pop, fifo_full, fifo_empty;

   tx_state_t         tx_state, tx_next;
   tx_phase_t         tx_phase, phase_next;
   logic [10:0]       frame;
   logic [7:0]        cur_byte;

   assign tick       = (tick_cnt == TICK_W'(SCAN_DIV - 1));
   assign tmo_expire = (tmo_cnt == TMO_W'(CONV_TIMEOUT - 1));
   assign ch_onehot  = 8'd1 << conv_ch;
   assign fifo_empty = (fifo_cnt == '0);
   assign fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
   // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
   assign fifo_push  = (scan_state == S_STORE) && (!fifo_full || fifo_pop);

   // Free-running scan-rate divider; it runs whether or not scanning is enabled.
   always_ff @(posedge clock) begin
      if (reset)
         tick_cnt <= '0;
      else if (tick)
         tick_cnt <= '0;
      else
         tick_cnt <= tick_cnt + TICK_W'(1);
   end

   // The channel being converted is the lowest bit still set in the round mask.
   // conv_ch therefore holds steady until S_NEXT clears that bit.
   always_comb begin
      conv_ch = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (round_mask[i])
            conv_ch = 3'(i);
      end
   end

   // Scan FSM next-state logic and outputs.
   // enable and ch_mask are only looked at when a round starts.
   always_comb begin
      scan_next  = scan_state;
      conv_start = 1'b0;
      scan_busy  = (scan_state != S_IDLE);
      case (scan_state)
         S_IDLE:  if (tick && enable && (ch_mask != 8'd0)) scan_next = S_START;
         S_START: begin
            conv_start = 1'b1;
            scan_next  = S_WAIT;
         end
         S_WAIT: begin
            if (conv_done)
               scan_next = S_STORE;
            else if (tmo_expire)
               scan_next = S_NEXT;
         end
         S_STORE: scan_next = S_NEXT;
         S_NEXT:  scan_next = ((round_mask & ~ch_onehot) != 8'd0) ? S_START : S_IDLE;
         default: scan_next = S_IDLE;
      endcase
   end

   // Scan FSM state and datapath: round mask, timeout counter, captured sample, error counters.
   always_ff @(posedge clock) begin
      if (reset) begin
         scan_state  <= S_IDLE;
         round_mask  <= 8'd0;
         tmo_cnt     <= '0;
         sample      <= 8'd0;
         ovf_cnt     <= 8'd0;
         timeout_err <= 1'b0;
      end else begin
         scan_state <= scan_next;
         case (scan_state)
            S_IDLE:  if (scan_next == S_START) round_mask <= ch_mask;
            S_START: tmo_cnt <= '0;
            S_WAIT: begin
               tmo_cnt <= tmo_cnt + TMO_W'(1);
               if (conv_done)
                  sample <= conv_data;
               else if (tmo_expire)
                  timeout_err <= 1'b1;
            end
            S_STORE: if (!fifo_push && (ovf_cnt != 8'hFF)) ovf_cnt <= ovf_cnt + 8'd1;
            S_NEXT:  round_mask <= round_mask & ~ch_onehot;
            default: ;
         endcase
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         fifo_cnt <= '0;
      end else begin
         if (fifo_push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (fifo_pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         case ({fifo_push, fifo_pop})
            2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
            2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
            default: ;
         endcase
      end
   end

   // FIFO storage. The head entry is read directly, so the FIFO is first-word-fall-through.
   always_ff @(posedge clock) begin
      if (fifo_push)
         fifo_mem[wr_ptr] <= {conv_ch, sample};
   end

   // TX FSM next-state logic and outputs.
   // Each byte is sent once, then the FSM waits for tx_ready to go low and then high again.
   always_comb begin
      tx_next    = tx_state;
      phase_next = tx_phase;
      tx_send    = 1'b0;
      tx_data    = 8'd0;
      fifo_pop   = 1'b0;
      case (tx_state)
         T_B0:    cur_byte = SYNC_BYTE;
         T_B1:    cur_byte = {5'd0, frame[10:8]};
         T_B2:    cur_byte = frame[7:0];
         default: cur_byte = 8'd0;
      endcase
      if (tx_state == T_IDLE) begin
         if (!fifo_empty && tx_ready) begin
            fifo_pop   = 1'b1;
            tx_next    = T_B0;
            phase_next = P_SEND;
         end
      end else begin
         case (tx_phase)
            P_SEND: if (tx_ready) begin
               tx_send    = 1'b1;
               tx_data    = cur_byte;
               phase_next = P_LOW;
            end
            P_LOW:  if (!tx_ready) phase_next = P_HIGH;
            P_HIGH: if (tx_ready) begin
               phase_next = P_SEND;
               case (tx_state)
                  T_B0:    tx_next = T_B1;
                  T_B1:    tx_next = T_B2;
                  default: tx_next = T_IDLE;
               endcase
            end
            default: phase_next = P_SEND;
         endcase
      end
   end

   // TX FSM state register and frame holding register.
   always_ff @(posedge clock) begin
      if (reset) begin
         tx_state <= T_IDLE;
         tx_phase <= P_SEND;
         frame    <= 11'd0;
      end else begin
         tx_state <= tx_next;
         tx_phase <= phase_next;
         if (fifo_pop)
            frame <= fifo_mem[rd_ptr];
      end
   end

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// tb_adc_scan_scheduler: directed bench with a behavioural ADC model and a behavioural UART model.
module tb_adc_scan_scheduler;

   localparam int SCAN_DIV     = 400;
   localparam int CONV_TIMEOUT = 100;
   localparam int FIFO_DEPTH   = 4;
   localparam int ADC_LAT      = 20;
   localparam int UART_BUSY    = 10;

   logic       clock;
   logic       reset;
   logic       enable;
   logic [7:0] ch_mask;
   logic       conv_start;
   logic [2:0] conv_ch;
   logic       conv_done;
   logic [7:0] conv_data;
   logic       tx_send;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       scan_busy;
   logic [7:0] ovf_cnt;
   logic       timeout_err;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] adc_table [8];
   int         mute_ch  = 8;
   logic       tx_hold  = 1'b0;
   logic [7:0] tx_log [$];
   logic [2:0] start_log [$];

   adc_scan_scheduler #(
      .SCAN_DIV(SCAN_DIV),
      .CONV_TIMEOUT(CONV_TIMEOUT),
      .FIFO_DEPTH(FIFO_DEPTH),
      .SYNC_BYTE(8'hA5)
   ) dut (
      .clock(clock),
      .reset(reset),
      .enable(enable),
      .ch_mask(ch_mask),
      .conv_start(conv_start),
      .conv_ch(conv_ch),
      .conv_done(conv_done),
      .conv_data(conv_data),
      .tx_send(tx_send),
      .tx_data(tx_data),
      .tx_ready(tx_ready),
      .scan_busy(scan_busy),
      .ovf_cnt(ovf_cnt),
      .timeout_err(timeout_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_conv_start"}, conv_start, 0);
      check({tag, "_conv_ch"}, conv_ch, 0);
      check({tag, "_tx_send"}, tx_send, 0);
      check({tag, "_tx_data"}, tx_data, 0);
      check({tag, "_scan_busy"}, scan_busy, 0);
      check({tag, "_ovf_cnt"}, ovf_cnt, 0);
      check({tag, "_timeout_err"}, timeout_err, 0);
   endtask

   task automatic wait_busy(input logic level, input int budget, input string tag);
      int n = 0;
      while (scan_busy !== level && n < budget) begin
         @(negedge clock);
         n++;
      end
      check(tag, scan_busy, level);
   endtask

   task automatic wait_bytes(input int cnt, input int budget, input string tag);
      int n = 0;
      while (tx_log.size() < cnt && n < budget) begin
         @(negedge clock);
         n++;
      end
      check(tag, tx_log.size(), cnt);
   endtask

   task automatic expect_frame(input string tag, input int base, input logic [2:0] ch, input logic [7:0] d);
      if (tx_log.size() < base + 3)
         check({tag, "_len"}, tx_log.size(), base + 3);
      else begin
         check({tag, "_sync"}, tx_log[base], 8'hA5);
         check({tag, "_ch"}, tx_log[base+1], {5'd0, ch});
         check({tag, "_data"}, tx_log[base+2], d);
         $display("frame %s: %02h %02h %02h", tag, tx_log[base], tx_log[base+1], tx_log[base+2]);
      end
   endtask

   task automatic expect_start(input string tag, input int idx, input logic [2:0] ch);
      if (start_log.size() <= idx)
         check({tag, "_len"}, start_log.size(), idx + 1);
      else
         check(tag, start_log[idx], ch);
   endtask

   task automatic clear_logs();
      tx_log.delete();
      start_log.delete();
   endtask

   // ADC model: answers each conv_start after ADC_LAT clocks, except on the muted channel.
   initial begin
      int         cnt;
      logic [2:0] ch;
      bit         busy;
      conv_done = 1'b0;
      conv_data = 8'd0;
      cnt  = 0;
      ch   = 3'd0;
      busy = 1'b0;
      forever begin
         @(negedge clock);
         conv_done = 1'b0;
         if (conv_start) begin
            busy = 1'b1;
            cnt  = ADC_LAT;
            ch   = conv_ch;
            start_log.push_back(conv_ch);
            $display("conv_start ch%0d at %0t", conv_ch, $time);
         end else if (busy) begin
            cnt--;
            if (cnt == 0) begin
               busy = 1'b0;
               if (int'(ch) != mute_ch) begin
                  conv_done = 1'b1;
                  conv_data = adc_table[ch];
               end
            end
         end
      end
   end

   // UART model: after each byte, tx_ready stays low for UART_BUSY clocks. tx_hold keeps it low.
   initial begin
      int cnt;
      cnt      = 0;
      tx_ready = 1'b1;
      forever begin
         @(negedge clock);
         if (reset) begin
            cnt      = 0;
            tx_ready = !tx_hold;
         end else if (tx_send) begin
            check("send_while_ready", tx_ready, 1);
            tx_log.push_back(tx_data);
            $display("tx byte %02h at %0t", tx_data, $time);
            cnt = UART_BUSY;
         end else if (cnt > 0) begin
            tx_ready = 1'b0;
            cnt--;
         end else begin
            tx_ready = !tx_hold;
         end
      end
   end

   initial begin
      reset   = 1'b1;
      enable  = 1'b0;
      ch_mask = 8'd0;
      for (int i = 0; i < 8; i++) adc_table[i] = 8'd0;
      repeat (3) @(negedge clock);
      check_reset_state("por");
      reset = 1'b0;

      // Two-channel round; enable drops mid-round and the round still completes.
      adc_table[0] = 8'h3C;
      adc_table[2] = 8'h7F;
      ch_mask = 8'b0000_0101;
      enable  = 1'b1;
      wait_busy(1'b1, 450, "s1_busy_rise");
      enable = 1'b0;
      wait_busy(1'b0, 200, "s1_busy_fall");
      check("s1_starts", start_log.size(), 2);
      expect_start("s1_first_ch", 0, 3'd0);
      expect_start("s1_second_ch", 1, 3'd2);
      wait_bytes(6, 300, "s1_bytes");
      expect_frame("s1_f0", 0, 3'd0, 8'h3C);
      expect_frame("s1_f1", 3, 3'd2, 8'h7F);

      // No round starts when enable is low at the tick, or when the mask is zero.
      repeat (450) @(negedge clock);
      check("en0_no_start", start_log.size(), 2);
      ch_mask = 8'd0;
      enable  = 1'b1;
      repeat (450) @(negedge clock);
      check("mask0_no_start", start_log.size(), 2);
      check("mask0_idle", scan_busy, 0);

      // A zero sample is still sent as a normal data byte.
      clear_logs();
      adc_table[5] = 8'h00;
      ch_mask = 8'h20;
      wait_busy(1'b1, 450, "s4_busy_rise");
      enable = 1'b0;
      wait_busy(1'b0, 200, "s4_busy_fall");
      expect_start("s4_ch", 0, 3'd5);
      wait_bytes(3, 200, "s4_bytes");
      expect_frame("s4_f0", 0, 3'd5, 8'h00);

      // Conversion timeout on ch1; the next round still scans both channels.
      clear_logs();
      adc_table[0] = 8'h21;
      adc_table[1] = 8'h42;
      mute_ch = 1;
      ch_mask = 8'h03;
      check("tmo_pre", timeout_err, 0);
      enable = 1'b1;
      wait_busy(1'b1, 450, "tmo_busy_rise");
      wait_busy(1'b0, 300, "tmo_busy_fall");
      check("tmo_flag", timeout_err, 1);
      check("tmo_starts", start_log.size(), 2);
      expect_start("tmo_ch1_started", 1, 3'd1);
      wait_bytes(3, 200, "tmo_bytes");
      expect_frame("tmo_f0", 0, 3'd0, 8'h21);
      mute_ch = 8;
      wait_busy(1'b1, 450, "tmo_r2_rise");
      enable = 1'b0;
      wait_busy(1'b0, 200, "tmo_r2_fall");
      check("tmo_r2_starts", start_log.size(), 4);
      wait_bytes(9, 300, "tmo_r2_bytes");
      expect_frame("tmo_r2_f0", 3, 3'd0, 8'h21);
      expect_frame("tmo_r2_f1", 6, 3'd1, 8'h42);
      check("tmo_sticky", timeout_err, 1);

      // All 8 channels with the UART stalled: 4 entries fit in the FIFO, 4 are dropped.
      clear_logs();
      for (int i = 0; i < 8; i++) adc_table[i] = 8'h10 + 8'(i);
      check("ovf_pre", ovf_cnt, 0);
      tx_hold = 1'b1;
      ch_mask = 8'hFF;
      enable  = 1'b1;
      wait_busy(1'b1, 450, "ovf_busy_rise");
      enable = 1'b0;
      wait_busy(1'b0, 300, "ovf_busy_fall");
      check("ovf_count", ovf_cnt, 4);
      check("ovf_no_tx", tx_log.size(), 0);
      check("ovf_starts", start_log.size(), 8);
      expect_start("ovf_last_ch", 7, 3'd7);
      repeat (310) @(negedge clock);
      tx_hold = 1'b0;
      wait_bytes(12, 400, "ovf_bytes");
      for (int i = 0; i < 4; i++)
         expect_frame($sformatf("ovf_f%0d", i), 3 * i, 3'(i), 8'h10 + 8'(i));
      repeat (100) @(negedge clock);
      check("ovf_only4", tx_log.size(), 12);

      // Reset while frame 1 waits after B1, ch2 sits in the FIFO, and ch3 is converting.
      clear_logs();
      for (int i = 0; i < 8; i++) adc_table[i] = 8'h30 + 8'(i);
      ch_mask = 8'h0F;
      enable  = 1'b1;
      wait_busy(1'b1, 450, "rst_busy_rise");
      wait_bytes(5, 200, "rst_pre_bytes");
      expect_frame("rst_pre_f0", 0, 3'd0, 8'h30);
      check("rst_mid_round", scan_busy, 1);
      check("rst_in_wait_ch", conv_ch, 3);
      reset = 1'b1;
      @(negedge clock);
      check_reset_state("rst_mid");
      reset = 1'b0;
      repeat (300) @(negedge clock);
      check("rst_no_stray_tx", tx_log.size(), 5);
      check("rst_no_stray_start", start_log.size(), 4);
      wait_busy(1'b1, 200, "rst_resume_rise");
      enable = 1'b0;
      wait_bytes(17, 500, "rst_resume_bytes");
      for (int i = 0; i < 4; i++)
         expect_frame($sformatf("rst_f%0d", i), 5 + 3 * i, 3'(i), 8'h30 + 8'(i));
      wait_busy(1'b0, 200, "rst_resume_fall");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/adc_scan_scheduler.md
Name: adc_scan_scheduler

Overview:
Sequences the 8-channel ADC conversion controller through an enabled-channel mask at a programmable scan rate. Buffers each result as a (channel, sample) entry in a small FIFO and schedules 3-byte frames onto the byte-wide UART transmitter. Sits between the ADC controller and uart_tx in the sensor transmit subsystem, replacing ad-hoc send gating with an explicit handshake.

Parameters:
SCAN_DIV, 50000, clocks between scan-round starts (>=16)
CONV_TIMEOUT, 4096, max clocks from conv_start to conv_done before abort
FIFO_DEPTH, 4, result FIFO entries (power of 2, >=2)
SYNC_BYTE, 8'hA5, first byte of every frame

Ports:
clock  in  1  single system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
enable  in  1  scan enable; sampled at round start only
ch_mask  in  8  bit i=1 -> channel i included in round
conv_start  out  1  1-cycle pulse requesting a conversion on conv_ch
conv_ch  out  3  channel address, stable from conv_start until conv_done/abort
conv_done  in  1  1-cycle pulse, conv_data valid same cycle
conv_data  in  8  conversion result
tx_send  out  1  1-cycle byte request to uart_tx
tx_data  out  8  byte, valid while tx_send=1
tx_ready  in  1  uart_tx idle
scan_busy  out  1  high from round start until last channel stored/aborted
ovf_cnt  out  8  dropped-sample count, saturates at 255
timeout_err  out  1  sticky, set on any conversion timeout

Behaviour:
- Reset: all outputs 0, conv_ch=0, tick counter=0, FIFO empty, both FSMs idle. Reset mid-conversion or mid-frame abandons it; no further byte issued.
- Tick counter: counts 0..SCAN_DIV-1, wraps; tick = count==SCAN_DIV-1. Runs regardless of enable.
- Scan FSM: S_IDLE -> (tick & enable & ch_mask!=0) S_START; ch_mask latched into round mask at that cycle. Tick with enable=0 or mask=0: stay S_IDLE.
- S_START: select lowest set bit of round mask -> conv_ch; pulse conv_start one cycle; -> S_WAIT; timeout counter cleared.
- S_WAIT: conv_done -> S_STORE (capture conv_data). Timeout counter reaches CONV_TIMEOUT -> set timeout_err, no FIFO write, -> S_NEXT. conv_done ignored in any other state.
- S_STORE: FIFO not full -> push {conv_ch, data}; full -> drop, ovf_cnt+1 (saturating). -> S_NEXT.
- S_NEXT: clear current bit in round mask; remaining bits -> S_START, none -> S_IDLE.
- scan_busy=1 in all states except S_IDLE. Tick during busy round ignored (round not restarted, not queued).
- Channel order ascending. Mid-round ch_mask changes ignored.
- FIFO: synchronous, first-word-fall-through, 11-bit entries. Push and pop in same cycle when full: pop frees slot, push accepted, no overflow counted.
- TX FSM: T_IDLE -> (FIFO non-empty & tx_ready) pop entry into frame register, -> T_B0.
- Each of T_B0/T_B1/T_B2: assert tx_send one cycle with tx_ready=1; then wait tx_ready=0, then tx_ready=1, before next byte. Bytes: B0=SYNC_BYTE, B1={5'b0,ch}, B2=data (0x00 sent normally). After B2 completes -> T_IDLE.
- tx_send never asserted while tx_ready=0; at most one send per ready low/high cycle.
- Latency: conv_done to FIFO write 1 cycle; FIFO non-empty & tx_ready to first tx_send <=2 cycles.
- Scan and TX FSMs independent; frames may be in flight while rounds run.

Test Plan:
- ch_mask=8'b0000_0101, enable=1, ADC model done 20 clocks after start with data 0x3C/0x7F -> conv_ch 0 then 2, frames A5 00 3C, A5 02 7F, scan_busy falls after second store.
- tx_ready held 0 for 500 clocks during a round on mask 8'hFF, FIFO_DEPTH=4 -> 4 entries kept (ch0-3), ovf_cnt=4, then frames for ch0-3 in order after release.
- ADC model never returns conv_done on ch1, mask 8'h03 -> abort after CONV_TIMEOUT, timeout_err=1, only ch0 frame sent, next round still scans ch0 and ch1.
- conv_data=0x00 on ch5 -> frame A5 05 00 transmitted.
- enable=0 at tick, or mask=0 -> no conv_start; enable drop mid-round -> round completes.
- Assert reset during T_B1 wait and during S_WAIT -> next cycle all outputs 0, FIFO empty, no stray tx_send; normal operation resumes on next tick.
